ahb_lsu_master: RTL and testbench
=================================

# ahb_lsu_master

Load/store bridge between the core's memory stage and the AHB-Lite fabric. It turns a single load/store request (address, store data, func3 width code) into one AHB-Lite NONSEQ transfer. It handles wait states and the two-cycle ERROR response, then returns aligned and sign- or zero-extended load data. It drives the haddr/htrans/hwrite/hsize/hprot/hwdata bus consumed by the address decoder and slave glue, and receives data and status from the response mux.

## Interface
Parameters:
- HPROT_VAL, 4'b0011: constant driven on hprot (data access, privileged).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- req_valid  input  1  core presents a request.
- req_ready  output  1  block can accept; high only in IDLE.
- mem_write  input  1  1 = store, 0 = load.
- func3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- alu_out  input  32  byte address.
- rs2_data  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_err  output  1  valid with rsp_valid: misaligned, illegal func3 or bus ERROR.
- rsp_data  output  32  extended load data; 0 for stores and errors.
- haddr  output  32  AHB address.
- htrans  output  2  00 IDLE, 10 NONSEQ.
- hwrite  output  1  AHB write.
- hsize  output  3  000/001/010 from func3[1:0].
- hprot  output  4  HPROT_VAL.
- hwdata  output  32  write data, lane-replicated.
- data_out_mux  input  32  hrdata from the response mux.
- hready  input  1  transfer-done from the mux.
- hresp  input  1  1 = ERROR from the mux.

## Operation
- States: IDLE, ADDR, DATA, ERR2.
- IDLE: req_ready=1. On req_valid, register the request and check it.
  - Illegal request: func3 not in {000, 001, 010, 100, 101}; func3 100/101 with mem_write=1; halfword with alu_out[0]=1; word with alu_out[1:0]≠00.
  - Illegal: no bus transfer; stay in IDLE; rsp_valid=1, rsp_err=1 next cycle.
  - Legal: go to ADDR.
- ADDR: htrans=NONSEQ; haddr, hwrite and hsize come from the registered request.
  - hready=1 → DATA.
  - hready=0 → hold all address-phase signals stable.
- DATA: htrans=IDLE; hwdata valid.
  - hready=1, hresp=0 → capture data_out_mux; go to IDLE; rsp_valid next cycle.
  - hready=0, hresp=1 → ERR2.
  - hready=0, hresp=0 → wait state; hold hwdata.
- ERR2: wait for hready=1 (second ERROR cycle), then go to IDLE with rsp_valid=1, rsp_err=1, rsp_data=0.
- hwdata formation:
  - B: {4{rs2_data[7:0]}}.
  - H: {2{rs2_data[15:0]}}.
  - W: rs2_data.
- Load extraction (little-endian):
  - Byte lane: addr[1:0]. Halfword lane: addr[1].
  - func3 000/001: sign-extend. 100/101: zero-extend. 010: pass through.
- One transfer outstanding; no address/data-phase overlap between consecutive requests.
- Address-phase signals are registered, with no combinational path from req_* to the bus. req_ready is decoded directly from state (high in IDLE).

## Timing
- Reset values:
  - State: IDLE.
  - Control: req_ready=1, rsp_valid=0, rsp_err=0, hwrite=0, htrans=00.
  - Buses: rsp_data=0, haddr=0, hsize=000, hwdata=0.
  - hprot: HPROT_VAL.
- Reset asserted mid-transfer returns to IDLE at the next edge with htrans=IDLE. The in-flight request gets no response.
- Zero-wait-state latency:
  - Acceptance at edge E.
  - ADDR in cycle E+1, DATA in E+2.
  - rsp_valid high in E+3, with req_ready=1 in the same cycle.
  - Throughput is one transfer per 3 cycles.
- Each wait state in ADDR or DATA adds one cycle.
- Bus ERROR path: DATA → ERR2 → IDLE. rsp_valid comes 1 cycle after the hready=1 ERR2 cycle.
- Illegal request: rsp_valid at E+1; no cycle with htrans≠IDLE.
- rsp_valid lasts exactly one cycle. The core must sample it; there is no back-pressure on responses.
- A request arriving on the rsp_valid cycle is accepted, because req_ready=1 then.

## Test plan
- SW, alu_out=B000_0000, rs2_data=12345678, zero wait:
  - Cycle E+1: htrans=10, hwrite=1, hsize=010.
  - Cycle E+2: hwdata=12345678.
  - Cycle E+3: rsp_valid, rsp_err=0.
- LB, alu_out=B000_0003, data_out_mux=80AB_CDEF, 2 wait states in DATA:
  - rsp_data=FFFF_FF80 at E+5.
  - Same stimulus with LBU: rsp_data=0000_0080.
- SH, alu_out=B000_0002, rs2_data=0000_BEEF:
  - hsize=001, hwdata=BEEF_BEEF.
  - Same stimulus with LHU read, data_out_mux=BEEF_1234: rsp_data=0000_BEEF.
- LW at alu_out=B000_0002, then SB with func3=100:
  - Both give rsp_valid, rsp_err=1 at E+1.
  - htrans stays 00 throughout.
- LW, alu_out=A000_0004; slave holds hready=0 for 1 ADDR cycle, then drives the ERROR pair (hresp=1 with hready 0 then 1):
  - haddr stable during the stall.
  - rsp_err=1, rsp_data=0 after ERR2.
- Reset asserted in the DATA cycle:
  - Next cycle: htrans=00, rsp_valid=0, req_ready=1.
  - A following SW completes normally.

Source files
------------

// File: rtl/ahb_lsu_master.sv
// Load/store bridge: turns one core memory request into a single AHB-Lite NONSEQ
// transfer, handles wait states and the two-cycle ERROR response, and returns extended load data.
module ahb_lsu_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_data,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] data_out_mux,
  input  logic        hready,
  input  logic        hresp
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR2} state_t;

  state_t      state, state_next;
  logic [31:0] req_addr;
  logic        req_write;
  logic [2:0]  req_func3;
  logic [31:0] wdata_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_data_q;

  logic        req_legal;
  logic        accept;
  logic        reject;
  logic        done_ok;
  logic        done_err;
  logic [31:0] wdata_repl;
  logic [31:0] lane_data;
  logic [31:0] load_data;

  // Unsupported widths, stores of unsigned widths and misaligned accesses never reach the bus.
  always_comb begin
    req_legal = 1'b1;
    case (func3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !mem_write;
      default:                req_legal = 1'b0;
    endcase
    if (func3[1:0] == 2'b01 && alu_out[0])
      req_legal = 1'b0;
    if (func3[1:0] == 2'b10 && alu_out[1:0] != 2'b00)
      req_legal = 1'b0;
  end

  always_comb begin
    case (func3[1:0])
      2'b00:   wdata_repl = {4{rs2_data[7:0]}};
      2'b01:   wdata_repl = {2{rs2_data[15:0]}};
      default: wdata_repl = rs2_data;
    endcase
  end

  // Alignment is guaranteed, so shifting the selected lane down to bit 0 serves bytes and halfwords.
  assign lane_data = data_out_mux >> {req_addr[1:0], 3'b000};

  always_comb begin
    case (req_func3)
      3'b000:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b001:  load_data = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b100:  load_data = {24'h000000, lane_data[7:0]};
      3'b101:  load_data = {16'h0000, lane_data[15:0]};
      default: load_data = data_out_mux;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    done_ok    = 1'b0;
    done_err   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_legal) begin
            accept     = 1'b1;
            state_next = ADDR;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ADDR: begin
        if (hready)
          state_next = DATA;
      end
      DATA: begin
        // A one-cycle ERROR (hready already high) is accepted as a complete error response.
        if (hresp) begin
          if (hready) begin
            done_err   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = ERR2;
          end
        end else if (hready) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end
      end
      ERR2: begin
        if (hready) begin
          done_err   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr    <= 32'h0;
      req_write   <= 1'b0;
      req_func3   <= 3'b000;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'h0;
      if (accept) begin
        req_addr  <= alu_out;
        req_write <= mem_write;
        req_func3 <= func3;
        wdata_q   <= wdata_repl;
      end
      if (reject || done_err) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
      end
      if (done_ok) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= req_write ? 32'h0 : load_data;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign htrans    = (state == ADDR) ? 2'b10 : 2'b00;
  assign haddr     = req_addr;
  assign hwrite    = req_write;
  assign hsize     = {1'b0, req_func3[1:0]};
  assign hprot     = HPROT_VAL;
  assign hwdata    = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ahb_lsu_master.sv
// Scoreboard bench for ahb_lsu_master: directed requests push expected responses,
// a negedge monitor pops and compares them, including the cycle they arrive in.
module tb_ahb_lsu_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] alu_out = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic [31:0] data_out_mux = 32'h0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;

  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;

  ahb_lsu_master #(.HPROT_VAL(4'b0011)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_write(mem_write), .func3(func3), .alu_out(alu_out), .rs2_data(rs2_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hprot(hprot), .hwdata(hwdata),
    .data_out_mux(data_out_mux), .hready(hready), .hresp(hresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rsp actual=rsp_valid=1 expected=no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        checkOutput("rsp_data", rsp_data, e.data);
        checkOutput("rsp_cycle", cyc, e.due);
      end
    end
  end

  // One request; the slave side inserts aw ADDR stalls, dw DATA wait states and an optional ERROR pair.
  task automatic applyStimulus(input string tag, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                               input int aw, input int dw, input bit berr, input bit illegal,
                               input logic [31:0] exp_hw, input logic exp_err, input logic [31:0] exp_data);
    exp_t e;
    checkOutput({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    mem_write = wr;
    func3 = f3;
    alu_out = addr;
    rs2_data = wd;
    data_out_mux = rd;
    req_valid = 1'b1;
    hready = 1'b1;
    hresp = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.err = exp_err;
    e.data = exp_data;
    if (illegal) begin
      e.due = cyc;
      sb.push_back(e);
      checkOutput({tag, "_htrans_idle"}, {30'b0, htrans}, 32'd0);
      return;
    end
    e.due = cyc + 2 + aw + dw + int'(berr);
    sb.push_back(e);
    for (int i = 0; i <= aw; i++) begin
      checkOutput({tag, "_htrans_nonseq"}, {30'b0, htrans}, 32'd2);
      checkOutput({tag, "_haddr"}, haddr, addr);
      checkOutput({tag, "_hwrite"}, {31'b0, hwrite}, {31'b0, wr});
      checkOutput({tag, "_hsize"}, {29'b0, hsize}, {29'b0, 1'b0, f3[1:0]});
      checkOutput({tag, "_hprot"}, {28'b0, hprot}, 32'h3);
      hready = (i == aw);
      @(posedge clk); #1;
    end
    for (int i = 0; i <= dw; i++) begin
      checkOutput({tag, "_htrans_data"}, {30'b0, htrans}, 32'd0);
      if (wr) checkOutput({tag, "_hwdata"}, hwdata, exp_hw);
      if (i < dw) begin
        hready = 1'b0; hresp = 1'b0;
      end else if (berr) begin
        hready = 1'b0; hresp = 1'b1;
      end else begin
        hready = 1'b1; hresp = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (berr) begin
      checkOutput({tag, "_htrans_err2"}, {30'b0, htrans}, 32'd0);
      hready = 1'b1;
      hresp = 1'b1;
      @(posedge clk); #1;
    end
    hready = 1'b1;
    hresp = 1'b0;
    checkOutput({tag, "_rsp_cycle_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'h0);
    checkOutput("rst_htrans", {30'b0, htrans}, 32'd0);
    checkOutput("rst_hwrite", {31'b0, hwrite}, 32'd0);
    checkOutput("rst_haddr", haddr, 32'h0);
    checkOutput("rst_hsize", {29'b0, hsize}, 32'd0);
    checkOutput("rst_hwdata", hwdata, 32'h0);
    checkOutput("rst_hprot", {28'b0, hprot}, 32'h3);
    reset = 1'b0;
    @(posedge clk); #1;

    // tag, wr, f3, addr, wdata, rdata, aw, dw, berr, illegal, exp hwdata, exp err, exp data
    applyStimulus("sw",  1'b1, 3'b010, 32'hB000_0000, 32'h1234_5678, 32'h0,          0, 0, 0, 0, 32'h1234_5678, 1'b0, 32'h0);
    applyStimulus("lb",  1'b0, 3'b000, 32'hB000_0003, 32'h0,          32'h80AB_CDEF, 0, 2, 0, 0, 32'h0,         1'b0, 32'hFFFF_FF80);
    applyStimulus("lbu", 1'b0, 3'b100, 32'hB000_0003, 32'h0,          32'h80AB_CDEF, 0, 2, 0, 0, 32'h0,         1'b0, 32'h0000_0080);
    applyStimulus("sh",  1'b1, 3'b001, 32'hB000_0002, 32'h0000_BEEF, 32'h0,          0, 0, 0, 0, 32'hBEEF_BEEF, 1'b0, 32'h0);
    applyStimulus("lhu", 1'b0, 3'b101, 32'hB000_0002, 32'h0,          32'hBEEF_1234, 0, 0, 0, 0, 32'h0,         1'b0, 32'h0000_BEEF);
    applyStimulus("lw",  1'b0, 3'b010, 32'hB000_0008, 32'h0,          32'hDEAD_BEEF, 0, 1, 0, 0, 32'h0,         1'b0, 32'hDEAD_BEEF);
    applyStimulus("lh",  1'b0, 3'b001, 32'hB000_0000, 32'h0,          32'h1234_8001, 0, 0, 0, 0, 32'h0,         1'b0, 32'hFFFF_8001);
    applyStimulus("sb",  1'b1, 3'b000, 32'hB000_0001, 32'h0000_00A5, 32'h0,          1, 0, 0, 0, 32'hA5A5_A5A5, 1'b0, 32'h0);

    // Illegal requests: misaligned word, store with an unsigned width, reserved width code.
    applyStimulus("lw_mis", 1'b0, 3'b010, 32'hB000_0002, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
    applyStimulus("sbu",    1'b1, 3'b100, 32'hB000_0000, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
    applyStimulus("f3_011", 1'b0, 3'b011, 32'hB000_0000, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
    @(posedge clk); #1;
    checkOutput("illegal_htrans_after", {30'b0, htrans}, 32'd0);

    applyStimulus("lw_err", 1'b0, 3'b010, 32'hA000_0004, 32'h0, 32'h5555_5555, 1, 0, 1, 0, 32'h0, 1'b1, 32'h0);

    // Reset in the DATA cycle aborts the transfer with no response.
    mem_write = 1'b0;
    func3 = 3'b010;
    alu_out = 32'hB000_0010;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("rstmid_htrans_addr", {30'b0, htrans}, 32'd2);
    @(posedge clk); #1;
    reset = 1'b1;
    hready = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstmid_htrans", {30'b0, htrans}, 32'd0);
    checkOutput("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
    reset = 1'b0;
    hready = 1'b1;
    @(posedge clk); #1;
    applyStimulus("sw_post", 1'b1, 3'b010, 32'hB000_0010, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 0, 32'hCAFE_F00D, 1'b0, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
